// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the vector ASIP pipeline hazard controller.
// Forwarding select encoding, vector-memory FSM states and default widths.
package pipeline_ctrl_pkg;

  localparam int REG_IDX_W_DFLT = 4;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    VMEM_IDLE = 1'b0,
    VMEM_BUSY = 1'b1
  } vmem_state_t;

  // The younger producer (MEM) holds the newer value, so it wins.
  function automatic fwd_sel_t fwd_pick(input logic mem_hit,
                                        input logic wb_hit);
    fwd_sel_t sel;
    sel = FWD_RF;
    priority case (1'b1)
      mem_hit: sel = FWD_MEM;
      wb_hit:  sel = FWD_WB;
      default: sel = FWD_RF;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_reg_match.sv
// One producer stage against one source operand.
// Same register file, live writer, same index; scalar R0 never matches.
module reg_match
  import pipeline_ctrl_pkg::*;
#(
  parameter int W = REG_IDX_W_DFLT
) (
  input  logic         p_valid,
  input  logic         p_wreg,
  input  logic         p_vf,
  input  logic [W-1:0] p_dest,
  input  logic         s_vf,
  input  logic [W-1:0] s_idx,
  output logic         hit
);

  assign hit = p_valid & p_wreg
             & (p_vf == s_vf)
             & (p_dest == s_idx)
             & (s_vf | (s_idx != '0));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage vector ASIP.
// Define FORWARD_EN for EX operand forwarding with load-use-only stalls.
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int VMEM_CYCLES = 4,
  parameter int REG_IDX_W   = REG_IDX_W_DFLT,
  parameter int PERF_CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic                  id_vf,
  input  logic                  id_use1,
  input  logic                  id_use2,
  input  logic [REG_IDX_W-1:0]  id_src1,
  input  logic [REG_IDX_W-1:0]  id_src2,
  input  logic                  ex_valid,
  input  logic                  ex_vf,
  input  logic                  ex_wreg,
  input  logic                  ex_rmem,
  input  logic [REG_IDX_W-1:0]  ex_dest,
  input  logic [REG_IDX_W-1:0]  ex_src1,
  input  logic [REG_IDX_W-1:0]  ex_src2,
  input  logic                  jmp_taken,
  input  logic                  mem_valid,
  input  logic                  mem_vf,
  input  logic                  mem_wreg,
  input  logic                  mem_rmem,
  input  logic                  mem_wmem,
  input  logic [REG_IDX_W-1:0]  mem_dest,
  input  logic                  wb_valid,
  input  logic                  wb_vf,
  input  logic                  wb_wreg,
  input  logic [REG_IDX_W-1:0]  wb_dest,
  output logic                  stall_if,
  output logic                  stall_id,
  output logic                  bubble_ex,
  output logic                  stall_mem,
  output logic                  flush_ifid,
  output logic                  flush_idex,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic [PERF_CNT_W-1:0] stall_cnt,
  output logic [PERF_CNT_W-1:0] flush_cnt
);

  localparam bit VMEM_STALLS = (VMEM_CYCLES > 1);
  localparam logic [2:0] CNT_INIT =
    VMEM_STALLS ? 3'(VMEM_CYCLES - 2) : 3'd0;

  vmem_state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [PERF_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [PERF_CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic vmem_stall, vmem_start, raw_hit;
  logic jmp_flush, raw_stall;

  logic [1:0][REG_IDX_W-1:0] id_src;
  logic [1:0] id_use, hit_ex;

  assign id_src = {id_src2, id_src1};
  assign id_use = {id_use2, id_use1};

  for (genvar s = 0; s < 2; s++) begin : g_id_ex
    reg_match #(.W(REG_IDX_W)) u_ex (
      .p_valid(ex_valid), .p_wreg(ex_wreg),
      .p_vf(ex_vf), .p_dest(ex_dest),
      .s_vf(id_vf), .s_idx(id_src[s]),
      .hit(hit_ex[s])
    );
  end

`ifdef FORWARD_EN
  logic [1:0][REG_IDX_W-1:0] ex_src;
  logic [1:0] fw_mem, fw_wb;
  fwd_sel_t sel_a, sel_b;

  assign ex_src = {ex_src2, ex_src1};

  for (genvar s = 0; s < 2; s++) begin : g_fwd
    reg_match #(.W(REG_IDX_W)) u_mem (
      .p_valid(mem_valid), .p_wreg(mem_wreg),
      .p_vf(mem_vf), .p_dest(mem_dest),
      .s_vf(ex_vf), .s_idx(ex_src[s]),
      .hit(fw_mem[s])
    );
    reg_match #(.W(REG_IDX_W)) u_wb (
      .p_valid(wb_valid), .p_wreg(wb_wreg),
      .p_vf(wb_vf), .p_dest(wb_dest),
      .s_vf(ex_vf), .s_idx(ex_src[s]),
      .hit(fw_wb[s])
    );
  end

  assign sel_a = fwd_pick(fw_mem[0], fw_wb[0]);
  assign sel_b = fwd_pick(fw_mem[1], fw_wb[1]);
  assign fwd_a = rst ? 2'b00 : sel_a;
  assign fwd_b = rst ? 2'b00 : sel_b;
  // Only a load result is too late to forward into EX.
  assign raw_hit = id_valid & ex_rmem & |(id_use & hit_ex);
`else
  logic [1:0] hit_mem, hit_wb;
  logic unused_fwd;

  for (genvar s = 0; s < 2; s++) begin : g_id_late
    reg_match #(.W(REG_IDX_W)) u_mem (
      .p_valid(mem_valid), .p_wreg(mem_wreg),
      .p_vf(mem_vf), .p_dest(mem_dest),
      .s_vf(id_vf), .s_idx(id_src[s]),
      .hit(hit_mem[s])
    );
    reg_match #(.W(REG_IDX_W)) u_wb (
      .p_valid(wb_valid), .p_wreg(wb_wreg),
      .p_vf(wb_vf), .p_dest(wb_dest),
      .s_vf(id_vf), .s_idx(id_src[s]),
      .hit(hit_wb[s])
    );
  end

  assign fwd_a = FWD_RF;
  assign fwd_b = FWD_RF;
  assign unused_fwd = ^{ex_src1, ex_src2, ex_rmem};
  assign raw_hit = id_valid
                 & |(id_use & (hit_ex | hit_mem | hit_wb));
`endif

  assign vmem_start = mem_valid & mem_vf
                    & (mem_rmem | mem_wmem) & VMEM_STALLS;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    vmem_stall = 1'b0;
    unique case (state_q)
      VMEM_IDLE: begin
        if (vmem_start) begin
          vmem_stall = 1'b1;
          cnt_d      = CNT_INIT;
          state_d    = VMEM_BUSY;
        end
      end
      VMEM_BUSY: begin
        vmem_stall = (cnt_q != 3'd0);
        cnt_d      = cnt_q - 3'd1;
        if (cnt_q == 3'd0) begin
          cnt_d   = 3'd0;
          state_d = VMEM_IDLE;
        end
      end
      default: begin
        cnt_d   = 3'd0;
        state_d = VMEM_IDLE;
      end
    endcase
  end

  // A jump flushes ID, so a RAW stall in the same cycle is moot.
  assign jmp_flush = !rst & jmp_taken & !vmem_stall;
  assign raw_stall = !rst & raw_hit & !vmem_stall & !jmp_taken;

  assign stall_mem  = !rst & vmem_stall;
  assign stall_if   = stall_mem | raw_stall;
  assign stall_id   = stall_mem | raw_stall;
  assign bubble_ex  = raw_stall;
  assign flush_ifid = jmp_flush;
  assign flush_idex = jmp_flush;

  assign stall_cnt_d = stall_cnt_q
    + PERF_CNT_W'(stall_if & ~&stall_cnt_q);
  assign flush_cnt_d = flush_cnt_q
    + PERF_CNT_W'(jmp_flush & ~&flush_cnt_q);

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= VMEM_IDLE;
      cnt_q       <= 3'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (default VMEM_CYCLES=4).
// Build-dependent RAW/forwarding vectors follow FORWARD_EN.
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic id_valid, id_vf, id_use1, id_use2;
  logic [3:0] id_src1, id_src2;
  logic ex_valid, ex_vf, ex_wreg, ex_rmem;
  logic [3:0] ex_dest, ex_src1, ex_src2;
  logic jmp_taken;
  logic mem_valid, mem_vf, mem_wreg, mem_rmem, mem_wmem;
  logic [3:0] mem_dest;
  logic wb_valid, wb_vf, wb_wreg;
  logic [3:0] wb_dest;
  logic stall_if, stall_id, bubble_ex, stall_mem;
  logic flush_ifid, flush_idex;
  logic [1:0] fwd_a, fwd_b;
  logic [15:0] stall_cnt, flush_cnt;

  int total = 0;
  int bad = 0;
  int es;

  pipeline_hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_vf(id_vf),
    .id_use1(id_use1), .id_use2(id_use2),
    .id_src1(id_src1), .id_src2(id_src2),
    .ex_valid(ex_valid), .ex_vf(ex_vf),
    .ex_wreg(ex_wreg), .ex_rmem(ex_rmem),
    .ex_dest(ex_dest),
    .ex_src1(ex_src1), .ex_src2(ex_src2),
    .jmp_taken(jmp_taken),
    .mem_valid(mem_valid), .mem_vf(mem_vf),
    .mem_wreg(mem_wreg), .mem_rmem(mem_rmem),
    .mem_wmem(mem_wmem), .mem_dest(mem_dest),
    .wb_valid(wb_valid), .wb_vf(wb_vf),
    .wb_wreg(wb_wreg), .wb_dest(wb_dest),
    .stall_if(stall_if), .stall_id(stall_id),
    .bubble_ex(bubble_ex), .stall_mem(stall_mem),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex),
    .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    id_valid = 0; id_vf = 0; id_use1 = 0; id_use2 = 0;
    id_src1 = 0; id_src2 = 0;
    ex_valid = 0; ex_vf = 0; ex_wreg = 0; ex_rmem = 0;
    ex_dest = 0; ex_src1 = 0; ex_src2 = 0;
    jmp_taken = 0;
    mem_valid = 0; mem_vf = 0; mem_wreg = 0;
    mem_rmem = 0; mem_wmem = 0; mem_dest = 0;
    wb_valid = 0; wb_vf = 0; wb_wreg = 0; wb_dest = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic vld(input logic [3:0] d);
    mem_valid = 1; mem_vf = 1; mem_rmem = 1;
    mem_wreg = 1; mem_dest = d;
  endtask

  initial begin
    rst = 1;
    clr();
    tick();
    // everything that could fire is presented while in reset
    jmp_taken = 1;
    id_valid = 1; id_use1 = 1; id_src1 = 4;
    ex_valid = 1; ex_wreg = 1; ex_rmem = 1; ex_dest = 4;
    vld(4'd3);
    @(negedge clk);
    check("rst_flush", flush_ifid, 0);
    check("rst_stall_if", stall_if, 0);
    check("rst_stall_mem", stall_mem, 0);
    check("rst_bubble", bubble_ex, 0);
    check("rst_scnt", stall_cnt, 0);
    check("rst_fcnt", flush_cnt, 0);
    tick();
    clr();
    rst = 0;

`ifdef FORWARD_EN
    // lw R5 in EX; add R6,R5,R2 in ID
    id_valid = 1; id_use1 = 1; id_use2 = 1;
    id_src1 = 5; id_src2 = 2;
    ex_valid = 1; ex_wreg = 1; ex_rmem = 1; ex_dest = 5;
    @(negedge clk);
    check("lu_bubble", bubble_ex, 1);
    check("lu_stall_if", stall_if, 1);
    check("lu_stall_id", stall_id, 1);
    tick();
    ex_valid = 0; ex_wreg = 0; ex_rmem = 0;
    mem_valid = 1; mem_wreg = 1; mem_rmem = 1; mem_dest = 5;
    @(negedge clk);
    check("lu_release", stall_if, 0);
    check("lu_sc_mem", stall_mem, 0);
    tick();
    clr();
    ex_valid = 1; ex_src1 = 5; ex_src2 = 2;
    wb_valid = 1; wb_wreg = 1; wb_dest = 5;
    @(negedge clk);
    check("fwd_wb_a", fwd_a, 2'b10);
    check("fwd_wb_b", fwd_b, 2'b00);
    tick();
    clr();
    ex_valid = 1; ex_vf = 1; ex_src1 = 2;
    mem_valid = 1; mem_vf = 1; mem_wreg = 1; mem_dest = 2;
    wb_valid = 1; wb_vf = 1; wb_wreg = 1; wb_dest = 2;
    @(negedge clk);
    check("fwd_mem_wins", fwd_a, 2'b01);
    tick();
    clr();
    ex_valid = 1; ex_src1 = 0;
    mem_valid = 1; mem_wreg = 1; mem_dest = 0;
    @(negedge clk);
    check("fwd_r0", fwd_a, 2'b00);
    es = 1;
`else
    // add R4 in EX; ID reads R4 while it walks EX, MEM, WB
    id_valid = 1; id_use1 = 1; id_src1 = 4;
    ex_valid = 1; ex_wreg = 1; ex_dest = 4;
    @(negedge clk);
    check("raw_ex_if", stall_if, 1);
    check("raw_ex_id", stall_id, 1);
    check("raw_ex_bub", bubble_ex, 1);
    tick();
    ex_valid = 0; ex_wreg = 0; ex_dest = 0;
    mem_valid = 1; mem_wreg = 1; mem_dest = 4;
    @(negedge clk);
    check("raw_mem", stall_if, 1);
    tick();
    mem_valid = 0; mem_wreg = 0; mem_dest = 0;
    wb_valid = 1; wb_wreg = 1; wb_dest = 4;
    @(negedge clk);
    check("raw_wb", bubble_ex, 1);
    tick();
    clr();
    id_valid = 1; id_use1 = 1; id_src1 = 0;
    ex_valid = 1; ex_wreg = 1; ex_dest = 0;
    @(negedge clk);
    check("raw_r0", stall_if, 0);
    tick();
    clr();
    id_valid = 1; id_use2 = 1; id_src2 = 4;
    ex_valid = 1; ex_wreg = 1; ex_vf = 1; ex_dest = 4;
    ex_src1 = 7;
    mem_valid = 1; mem_wreg = 1; mem_dest = 7;
    @(negedge clk);
    check("raw_vf_diff", stall_if, 0);
    check("nofwd_a", fwd_a, 2'b00);
    es = 3;
`endif
    tick();
    clr();
    @(negedge clk);
    check("raw_scnt", stall_cnt, es);

    // taken jump, no stall
    tick();
    jmp_taken = 1;
    @(negedge clk);
    check("jmp_ifid", flush_ifid, 1);
    check("jmp_idex", flush_idex, 1);
    check("jmp_fcnt0", flush_cnt, 0);
    // jump beats a load-use RAW
    tick();
    id_valid = 1; id_use1 = 1; id_src1 = 4;
    ex_valid = 1; ex_wreg = 1; ex_rmem = 1; ex_dest = 4;
    @(negedge clk);
    check("jraw_flush", flush_idex, 1);
    check("jraw_bubble", bubble_ex, 0);
    check("jraw_stall", stall_if, 0);
    check("jraw_fcnt1", flush_cnt, 1);
    tick();
    clr();
    @(negedge clk);
    check("jmp_off", flush_ifid, 0);
    check("jmp_fcnt2", flush_cnt, 2);

    // vector load V3 occupies MEM for 4 cycles
    tick();
    vld(4'd3);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      @(negedge clk);
      check("vld_smem", stall_mem, (i < 3));
      check("vld_sif", stall_if, (i < 3));
      check("vld_bub", bubble_ex, 0);
    end
    tick();
    clr();
    @(negedge clk);
    check("vld_noretrig", stall_mem, 0);
    check("vld_scnt", stall_cnt, es + 3);

    // jump held during a vector store stall
    tick();
    mem_valid = 1; mem_vf = 1; mem_wmem = 1;
    jmp_taken = 1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      @(negedge clk);
      check("jst_flush", flush_ifid, (i == 3));
      check("jst_smem", stall_mem, (i < 3));
    end
    tick();
    clr();
    @(negedge clk);
    check("jst_once", flush_ifid, 0);
    check("jst_fcnt3", flush_cnt, 3);

    // reset pulse in the middle of a vector access
    tick();
    vld(4'd3);
    @(negedge clk);
    check("rb_start", stall_mem, 1);
    tick();
    #2;
    rst = 1;
    jmp_taken = 1;
    @(negedge clk);
    check("rb_smem", stall_mem, 0);
    check("rb_sif", stall_if, 0);
    check("rb_flush", flush_idex, 0);
    check("rb_scnt", stall_cnt, 0);
    check("rb_fcnt", flush_cnt, 0);
    tick();
    clr();
    rst = 0;
    @(negedge clk);
    check("rb_after", stall_mem, 0);
    tick();
    @(negedge clk);
    check("rb_after2", stall_if, 0);
    check("rb_scnt2", stall_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
